// File: rtl/memory_access_stage.sv
// EX/MEM register, data-memory req/ack access with timeout fault, branch resolve and registered MEM/WB bundle.
// Optional build macro MEM_ALIGN_CHECK_EN faults misaligned memory ops without issuing a request.
module memory_access_stage #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              branch,
   input  logic              reg_write,
   input  logic              mem_to_reg,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] branch_target,
   input  logic [4:0]        write_register,
   input  logic              zero,

   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,

   output logic              pc_src,
   output logic [DATA_W-1:0] pc_branch,

   output logic              wb_valid,
   output logic              wb_reg_write,
   output logic              wb_mem_to_reg,
   output logic [DATA_W-1:0] wb_read_data,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [4:0]        wb_write_register,
   output logic              mem_fault
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t            state_reg;
   logic [7:0]        count_reg;

   // EX/MEM register
   logic              exm_is_load_reg;
   logic              exm_reg_write_reg;
   logic              exm_mem_to_reg_reg;
   logic              exm_take_branch_reg;
   logic [DATA_W-1:0] exm_branch_target_reg;
   logic [DATA_W-1:0] exm_alu_result_reg;
   logic [4:0]        exm_write_register_reg;

   logic              dmem_req_reg;
   logic              dmem_we_reg;
   logic [DATA_W-1:0] dmem_addr_reg;
   logic [DATA_W-1:0] dmem_wdata_reg;

   logic              pc_src_reg;
   logic [DATA_W-1:0] pc_branch_reg;
   logic              wb_valid_reg;
   logic              wb_reg_write_reg;
   logic              wb_mem_to_reg_reg;
   logic [DATA_W-1:0] wb_read_data_reg;
   logic [DATA_W-1:0] wb_alu_result_reg;
   logic [4:0]        wb_write_register_reg;
   logic              mem_fault_reg;

   logic              accept;
   logic              mem_op;
   logic              misaligned;
   logic              ack_fire;
   logic              timeout_fire;
   logic              direct_retire;
   logic              retire;
   logic              fault;
   logic              ret_reg_write;
   logic              ret_mem_to_reg;
   logic              ret_take_branch;
   logic [DATA_W-1:0] ret_alu_result;
   logic [DATA_W-1:0] ret_branch_target;
   logic [DATA_W-1:0] ret_read_data;
   logic [4:0]        ret_write_register;

   assign ex_ready = (state_reg == IDLE) && rst_n;

   always_comb begin
      accept       = ex_valid && ex_ready;
      mem_op       = mem_read || mem_write;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned   = (alu_result[1:0] != 2'b00);
`else
      misaligned   = 1'b0;
`endif
      ack_fire     = dmem_req_reg && dmem_ack;
      timeout_fire = dmem_req_reg && !dmem_ack && (count_reg == TIMEOUT_LAST);

      // Non-memory ops and rejected misaligned ops retire straight from the inputs.
      direct_retire = accept && (!mem_op || misaligned);
      retire        = direct_retire || ack_fire || timeout_fire;
      fault         = (accept && mem_op && misaligned) || timeout_fire;

      ret_reg_write      = exm_reg_write_reg;
      ret_mem_to_reg     = exm_mem_to_reg_reg;
      ret_take_branch    = exm_take_branch_reg;
      ret_alu_result     = exm_alu_result_reg;
      ret_branch_target  = exm_branch_target_reg;
      ret_write_register = exm_write_register_reg;
      ret_read_data      = '0;
      if (direct_retire) begin
         ret_reg_write      = reg_write;
         ret_mem_to_reg     = mem_to_reg;
         ret_take_branch    = branch && zero;
         ret_alu_result     = alu_result;
         ret_branch_target  = branch_target;
         ret_write_register = write_register;
      end else if (ack_fire && exm_is_load_reg) begin
         ret_read_data = dmem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg              <= IDLE;
         count_reg              <= '0;
         exm_is_load_reg        <= 1'b0;
         exm_reg_write_reg      <= 1'b0;
         exm_mem_to_reg_reg     <= 1'b0;
         exm_take_branch_reg    <= 1'b0;
         exm_branch_target_reg  <= '0;
         exm_alu_result_reg     <= '0;
         exm_write_register_reg <= '0;
         dmem_req_reg           <= 1'b0;
         dmem_we_reg            <= 1'b0;
         dmem_addr_reg          <= '0;
         dmem_wdata_reg         <= '0;
         pc_src_reg             <= 1'b0;
         pc_branch_reg          <= '0;
         wb_valid_reg           <= 1'b0;
         wb_reg_write_reg       <= 1'b0;
         wb_mem_to_reg_reg      <= 1'b0;
         wb_read_data_reg       <= '0;
         wb_alu_result_reg      <= '0;
         wb_write_register_reg  <= '0;
         mem_fault_reg          <= 1'b0;
      end else begin
         // Writeback and branch outputs are single-cycle pulses; data fields read 0 between them.
         wb_valid_reg          <= retire;
         wb_reg_write_reg      <= retire && ret_reg_write && !fault;
         wb_mem_to_reg_reg     <= retire && ret_mem_to_reg;
         wb_read_data_reg      <= retire ? ret_read_data : '0;
         wb_alu_result_reg     <= retire ? ret_alu_result : '0;
         wb_write_register_reg <= retire ? ret_write_register : '0;
         pc_src_reg            <= retire && ret_take_branch;
         pc_branch_reg         <= (retire && ret_take_branch) ? ret_branch_target : '0;
         mem_fault_reg         <= fault;

         if (state_reg == IDLE) begin
            if (accept) begin
               exm_is_load_reg        <= mem_read;
               exm_reg_write_reg      <= reg_write;
               exm_mem_to_reg_reg     <= mem_to_reg;
               exm_take_branch_reg    <= branch && zero;
               exm_branch_target_reg  <= branch_target;
               exm_alu_result_reg     <= alu_result;
               exm_write_register_reg <= write_register;
               if (mem_op && !misaligned) begin
                  state_reg      <= ACCESS;
                  count_reg      <= '0;
                  dmem_req_reg   <= 1'b1;
                  dmem_we_reg    <= mem_write && !mem_read;
                  dmem_addr_reg  <= alu_result;
                  dmem_wdata_reg <= write_data;
               end
            end
         end else begin
            if (ack_fire || timeout_fire) begin
               state_reg      <= IDLE;
               count_reg      <= '0;
               dmem_req_reg   <= 1'b0;
               dmem_we_reg    <= 1'b0;
               dmem_addr_reg  <= '0;
               dmem_wdata_reg <= '0;
            end else begin
               count_reg <= count_reg + 8'd1;
            end
         end
      end
   end

   assign dmem_req          = dmem_req_reg;
   assign dmem_we           = dmem_we_reg;
   assign dmem_addr         = dmem_addr_reg;
   assign dmem_wdata        = dmem_wdata_reg;
   assign pc_src            = pc_src_reg;
   assign pc_branch         = pc_branch_reg;
   assign wb_valid          = wb_valid_reg;
   assign wb_reg_write      = wb_reg_write_reg;
   assign wb_mem_to_reg     = wb_mem_to_reg_reg;
   assign wb_read_data      = wb_read_data_reg;
   assign wb_alu_result     = wb_alu_result_reg;
   assign wb_write_register = wb_write_register_reg;
   assign mem_fault         = mem_fault_reg;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: stimulus queues expected WB bundles and per-cycle port values,
// a negedge monitor pops and compares them.
module tb_memory_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready;
   logic        mem_read, mem_write, branch, reg_write, mem_to_reg, zero;
   logic [31:0] alu_result, write_data, branch_target;
   logic [4:0]  write_register;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        pc_src;
   logic [31:0] pc_branch;
   logic        wb_valid, wb_reg_write, wb_mem_to_reg, mem_fault;
   logic [31:0] wb_read_data, wb_alu_result;
   logic [4:0]  wb_write_register;

   always #5 clk = ~clk;

   memory_access_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
      .write_register(write_register), .zero(zero),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .pc_src(pc_src), .pc_branch(pc_branch),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
      .wb_write_register(wb_write_register), .mem_fault(mem_fault)
   );

   typedef struct {
      int          cyc;
      logic        rw;
      logic        m2r;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wr;
      logic        ps;
      logic [31:0] pb;
      logic        flt;
   } wb_exp_t;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
   } sig_exp_t;

   localparam int S_RDY = 0, S_REQ = 1, S_WE = 2, S_ADDR = 3, S_WDATA = 4;

   wb_exp_t  sb_q[$];
   sig_exp_t sig_q[$];
   int       cyc = 0;
   int       n_checks = 0;
   int       n_fails = 0;
   bit       done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic logic [31:0] sig_val(input int sel);
      case (sel)
         S_RDY:   return {31'd0, ex_ready};
         S_REQ:   return {31'd0, dmem_req};
         S_WE:    return {31'd0, dmem_we};
         S_ADDR:  return dmem_addr;
         default: return dmem_wdata;
      endcase
   endfunction

   function automatic string sig_name(input int sel);
      case (sel)
         S_RDY:   return "ex_ready";
         S_REQ:   return "dmem_req";
         S_WE:    return "dmem_we";
         S_ADDR:  return "dmem_addr";
         default: return "dmem_wdata";
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      wb_exp_t  e;
      sig_exp_t s;
      if (wb_valid) begin
         $display("WB  cyc=%0d rw=%0b m2r=%0b rd=0x%0h alu=0x%0h wr=%0d pc_src=%0b pc_branch=0x%0h fault=%0b",
                  cyc, wb_reg_write, wb_mem_to_reg, wb_read_data, wb_alu_result,
                  wb_write_register, pc_src, pc_branch, mem_fault);
         if (sb_q.size() == 0) begin
            chk("unexpected_wb_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("wb_cycle",          cyc,                       e.cyc);
            chk("wb_reg_write",      {31'd0, wb_reg_write},     {31'd0, e.rw});
            chk("wb_mem_to_reg",     {31'd0, wb_mem_to_reg},    {31'd0, e.m2r});
            chk("wb_read_data",      wb_read_data,              e.rd);
            chk("wb_alu_result",     wb_alu_result,             e.alu);
            chk("wb_write_register", {27'd0, wb_write_register}, {27'd0, e.wr});
            chk("pc_src",            {31'd0, pc_src},           {31'd0, e.ps});
            chk("pc_branch",         pc_branch,                 e.pb);
            chk("mem_fault",         {31'd0, mem_fault},        {31'd0, e.flt});
         end
      end else begin
         chk("idle_outputs_zero",
             {31'd0, (wb_reg_write | wb_mem_to_reg | pc_src | mem_fault |
                      (|wb_read_data) | (|wb_alu_result) | (|wb_write_register) | (|pc_branch))},
             32'd0);
      end

      while (sig_q.size() > 0 && sig_q[0].cyc <= cyc) begin
         s = sig_q.pop_front();
         if (s.cyc < cyc) chk("sig_missed_cycle", cyc, s.cyc);
         else             chk(sig_name(s.sel), sig_val(s.sel), s.val);
      end

      if (done) begin
         chk("scoreboard_drained", sb_q.size(), 32'd0);
         chk("sig_queue_drained",  sig_q.size(), 32'd0);
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_sig(input int c, input int sel, input logic [31:0] v);
      sig_exp_t s;
      s.cyc = c; s.sel = sel; s.val = v;
      sig_q.push_back(s);
   endtask

   task automatic push_wb(input int c, input logic rw, input logic m2r, input logic [31:0] rd,
                          input logic [31:0] alu, input logic [4:0] wr, input logic ps,
                          input logic [31:0] pb, input logic flt);
      wb_exp_t e;
      e.cyc = c; e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu;
      e.wr = wr; e.ps = ps; e.pb = pb; e.flt = flt;
      sb_q.push_back(e);
   endtask

   task automatic send(input logic mr, input logic mw, input logic br, input logic rw, input logic m2r,
                       input logic z, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] bt, input logic [4:0] wr);
      mem_read = mr; mem_write = mw; branch = br; reg_write = rw; mem_to_reg = m2r;
      zero = z; alu_result = alu; write_data = wd; branch_target = bt; write_register = wr;
      ex_valid = 1'b1;
   endtask

   initial begin : stimulus
      int t;
      rst_n = 1'b0; ex_valid = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
      zero = 1'b0; alu_result = '0; write_data = '0; branch_target = '0; write_register = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;

      // Reset state
      tick(); tick();
      exp_sig(cyc, S_RDY, 0); exp_sig(cyc, S_REQ, 0); exp_sig(cyc, S_WE, 0);
      exp_sig(cyc, S_ADDR, 0); exp_sig(cyc, S_WDATA, 0);
      tick();
      rst_n = 1'b1;
      exp_sig(cyc, S_RDY, 1);
      tick();

      // Back-to-back non-memory ops
      t = cyc;
      send(0, 0, 0, 1, 0, 0, 32'h5, 32'h0, 32'h0, 5'd3);
      push_wb(t + 1, 1, 0, 32'h0, 32'h5, 5'd3, 0, 32'h0, 0);
      exp_sig(t, S_RDY, 1);
      tick();
      send(0, 0, 0, 1, 0, 0, 32'h7, 32'h0, 32'h0, 5'd4);
      push_wb(t + 2, 1, 0, 32'h0, 32'h7, 5'd4, 0, 32'h0, 0);
      exp_sig(t + 1, S_RDY, 1);
      tick();
      ex_valid = 1'b0;
      exp_sig(t + 2, S_RDY, 1);
      tick();

      // Load at 0x40, ACK in third REQ cycle, branch taken carried through the access
      t = cyc;
      send(1, 0, 1, 1, 1, 1, 32'h40, 32'h0, 32'h500, 5'd7);
      push_wb(t + 4, 1, 1, 32'hDEADBEEF, 32'h40, 5'd7, 1, 32'h500, 0);
      exp_sig(t + 1, S_RDY, 0); exp_sig(t + 1, S_REQ, 1); exp_sig(t + 1, S_WE, 0);
      exp_sig(t + 1, S_ADDR, 32'h40);
      exp_sig(t + 2, S_RDY, 0);
      exp_sig(t + 3, S_RDY, 0); exp_sig(t + 3, S_REQ, 1); exp_sig(t + 3, S_ADDR, 32'h40);
      exp_sig(t + 4, S_RDY, 1); exp_sig(t + 4, S_REQ, 0);
      tick();
      ex_valid = 1'b0; dmem_rdata = 32'h11111111;
      tick(); tick();
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      tick();

      // Store to 0x80, ACK already high at accept (ignored) and in the first REQ cycle
      t = cyc;
      send(0, 1, 0, 0, 0, 0, 32'h80, 32'h12345678, 32'h0, 5'd0);
      dmem_ack = 1'b1;
      push_wb(t + 2, 0, 0, 32'h0, 32'h80, 5'd0, 0, 32'h0, 0);
      exp_sig(t, S_RDY, 1);
      exp_sig(t + 1, S_RDY, 0); exp_sig(t + 1, S_REQ, 1); exp_sig(t + 1, S_WE, 1);
      exp_sig(t + 1, S_ADDR, 32'h80); exp_sig(t + 1, S_WDATA, 32'h12345678);
      exp_sig(t + 2, S_RDY, 1); exp_sig(t + 2, S_REQ, 0); exp_sig(t + 2, S_WE, 0);
      tick();
      ex_valid = 1'b0;
      tick();
      dmem_ack = 1'b0;
      tick();

      // Read and write both set: read wins
      t = cyc;
      send(1, 1, 0, 1, 1, 0, 32'hC0, 32'hFFFF0000, 32'h0, 5'd6);
      dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
      push_wb(t + 2, 1, 1, 32'h0BADF00D, 32'hC0, 5'd6, 0, 32'h0, 0);
      exp_sig(t + 1, S_REQ, 1); exp_sig(t + 1, S_WE, 0);
      tick();
      ex_valid = 1'b0;
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      tick();

      // Branch taken, then not taken
      t = cyc;
      send(0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h2000, 5'd0);
      push_wb(t + 1, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'h2000, 0);
      tick();
      send(0, 0, 1, 1, 0, 0, 32'h9, 32'h0, 32'h3000, 5'd5);
      push_wb(t + 2, 1, 0, 32'h0, 32'h9, 5'd5, 0, 32'h0, 0);
      tick();
      ex_valid = 1'b0;
      tick();

      // Timeout: no ACK for four REQ cycles
      t = cyc;
      send(1, 0, 0, 1, 1, 0, 32'h200, 32'h0, 32'h0, 5'd9);
      push_wb(t + 5, 0, 1, 32'h0, 32'h200, 5'd9, 0, 32'h0, 1);
      exp_sig(t + 1, S_REQ, 1); exp_sig(t + 4, S_RDY, 0); exp_sig(t + 4, S_REQ, 1);
      exp_sig(t + 5, S_RDY, 1); exp_sig(t + 5, S_REQ, 0);
      tick();
      ex_valid = 1'b0;
      repeat (5) tick();

`ifdef MEM_ALIGN_CHECK_EN
      // Misaligned load is faulted without a request
      t = cyc;
      send(1, 0, 0, 1, 1, 0, 32'h41, 32'h0, 32'h0, 5'd2);
      push_wb(t + 1, 0, 1, 32'h0, 32'h41, 5'd2, 0, 32'h0, 1);
      exp_sig(t + 1, S_REQ, 0); exp_sig(t + 1, S_RDY, 1);
      tick();
      ex_valid = 1'b0;
      tick();
`else
      // Misaligned load proceeds with the full address
      t = cyc;
      send(1, 0, 0, 1, 1, 0, 32'h41, 32'h0, 32'h0, 5'd2);
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
      push_wb(t + 2, 1, 1, 32'hCAFEF00D, 32'h41, 5'd2, 0, 32'h0, 0);
      exp_sig(t + 1, S_REQ, 1); exp_sig(t + 1, S_ADDR, 32'h41);
      tick();
      ex_valid = 1'b0;
      tick();
      dmem_ack = 1'b0; dmem_rdata = '0;
      tick();
`endif

      // Reset during ACCESS drops the store with no writeback
      t = cyc;
      send(0, 1, 0, 1, 0, 0, 32'h100, 32'hA5A5A5A5, 32'h0, 5'd1);
      exp_sig(t + 1, S_REQ, 1); exp_sig(t + 1, S_ADDR, 32'h100);
      tick();
      ex_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      exp_sig(t + 2, S_REQ, 0); exp_sig(t + 2, S_RDY, 0); exp_sig(t + 2, S_ADDR, 0);
      tick();
      rst_n = 1'b1;
      exp_sig(t + 3, S_RDY, 1); exp_sig(t + 3, S_REQ, 0);
      exp_sig(t + 4, S_RDY, 1); exp_sig(t + 4, S_REQ, 0);
      repeat (4) tick();

      done = 1'b1;
      repeat (10) @(posedge clk);
      $display("FAIL watchdog: monitor did not end the run");
      $fatal(1);
   end

endmodule
